id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection for the 5-stage RV32I core.
//  Captures the decoded instruction, PC, register operands and immediate each cycle.
//  Its ID_EX_* outputs feed the EX-stage forwarding mux and the ALU.
//  Stalls IF/ID for one cycle and inserts a NOP bubble when a load feeds the next instruction.
//  Also inserts a bubble when the branch unit requests a flush.
// PARAMETERS
//  XLEN      32            datapath width of PC, operands and immediate
//  NOP_INSTR 32'h00000013  bubble encoding (addi x0,x0,0)
//  CNT_W     32            width of stall counter (STALL_COUNT_EN only)
// PORTS
//  clk          in   1     core clock, all state updates on rising edge
//  rst          in   1     synchronous reset, active-high
//  IF_ID_IR     in   32    instruction in decode
//  IF_ID_PC     in   XLEN  PC of IF_ID_IR
//  rs1_data     in   XLEN  register file read port 1 (IF_ID_IR[19:15])
//  rs2_data     in   XLEN  register file read port 2 (IF_ID_IR[24:20])
//  imm          in   XLEN  sign-extended immediate from decoder
//  flush        in   1     branch/jump taken in EX; squash instruction in decode
//  ID_EX_IR     out  32    registered instruction
//  ID_EX_PC     out  XLEN  registered PC
//  ID_EX_A      out  XLEN  registered rs1 operand
//  ID_EX_B      out  XLEN  registered rs2 operand
//  ID_EX_Imm    out  XLEN  registered immediate
//  ID_EX_valid  out  1     1 = real instruction, 0 = bubble
//  pc_write     out  1     combinational; 0 freezes PC
//  if_id_write  out  1     combinational; 0 freezes IF/ID register
//  stall_count  out  CNT_W load-use stall cycles (STALL_COUNT_EN only)
// BEHAVIOUR
//  Reset (rst=1 at edge): ID_EX_IR=NOP_INSTR, PC/A/B/Imm=0, ID_EX_valid=0, stall_count=0.
//  Reset overrides stall and flush. A reset mid-stall leaves no pending stall afterwards.
//  Load in EX: ID_EX_valid=1, ID_EX_IR[6:0]=7'b0000011, rd=ID_EX_IR[11:7]!=0.
//  rs1 used: all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111.
//  rs2 used: only R 0110011, S 0100011, B 1100011.
//  hazard: load in EX && ((rs1 used && rd==IF_ID_IR[19:15]) || (rs2 used && rd==IF_ID_IR[24:20])).
//  x0 never creates a hazard.
//  Stall cycle, hazard=1 and flush=0:
//   - pc_write=0 and if_id_write=0.
//   - Next edge loads a bubble: IR=NOP_INSTR, valid=0, PC/A/B/Imm=0.
//  Following cycle: the load has left EX, so hazard=0 and the held instruction advances.
//   - Exactly one bubble per load-use. Forwarding from MEM/WB supplies the loaded value.
//  flush=1: next edge loads a bubble. pc_write=1 and if_id_write=1 for the redirect.
//  Flush wins over hazard in the same cycle. The stalled instruction is squashed, so no stall.
//  Normal cycle: next edge registers IF_ID_IR, IF_ID_PC, rs1_data, rs2_data, imm.
//   - ID_EX_valid=1.
//  Latency: 1 cycle from decode inputs to ID_EX_* outputs. pc_write/if_id_write have 0 latency.
//  Back-to-back loads feeding each other each take exactly one stall.
// CONFIGURATION
//  STALL_COUNT_EN defined:
//   - stall_count exists and increments by 1 on every edge where hazard=1, flush=0, rst=0.
//   - Wraps at 2^CNT_W-1 -> 0.
//  STALL_COUNT_EN undefined: stall_count port and counter are absent. No other behaviour changes.
// TESTING
//  1. rst=1 for 2 cycles -> ID_EX_IR=32'h00000013, valid=0, A=B=0, pc_write=1.
//  2. lw x5,0(x1) then add x6,x5,x2:
//     - pc_write=if_id_write=0 for 1 cycle, one bubble inserted.
//     - add reaches EX next cycle, stall_count=1.
//  3. lw x0,0(x1) then add x6,x0,x2 -> no stall, add in EX one cycle after lw.
//  4. lw x5 then lui x5,0x12345 -> no stall.
//     lw x5 then sw x5,4(x2) -> stall (rs2 used).
//  5. lw x5 then add x6,x5,x2 with flush=1 in the hazard cycle:
//     - bubble inserted, pc_write=1, no stall, stall_count unchanged.
//  6. rst asserted during the stall cycle -> reset values next edge, pc_write=1 afterwards.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection
// for the 5-stage RV32I core.
//
// Each cycle it captures the decoded instruction, PC, register operands and
// immediate. When the instruction in EX is a load whose rd is read by the
// instruction in decode, the PC and IF/ID are frozen for one cycle and a NOP
// bubble goes into EX. A flush from the branch unit also inserts a bubble.
// A flush overrides the load-use stall, because the stalled instruction is
// being squashed anyway.
//
// Optional feature (macro STALL_COUNT_EN): adds the stall_count output and a
// wrapping counter of load-use stall cycles.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   IF_ID_IR/PC              instruction in decode and its PC
//   rs1_data/rs2_data/imm    register file reads and sign-extended immediate
//   flush                    squash the instruction in decode
//   ID_EX_IR/PC/A/B/Imm      registered payload for EX
//   ID_EX_valid              1 = real instruction, 0 = bubble
//   pc_write, if_id_write    combinational; 0 freezes PC / IF/ID
//   stall_count              load-use stall cycles (STALL_COUNT_EN only)
module id_ex_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     IF_ID_IR,
  input  logic [XLEN-1:0] IF_ID_PC,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic [31:0]     ID_EX_IR,
  output logic [XLEN-1:0] ID_EX_PC,
  output logic [XLEN-1:0] ID_EX_A,
  output logic [XLEN-1:0] ID_EX_B,
  output logic [XLEN-1:0] ID_EX_Imm,
  output logic            ID_EX_valid,
  output logic            pc_write,
`ifdef STALL_COUNT_EN
  output logic            if_id_write,
  output logic [CNT_W-1:0] stall_count
`else
  output logic            if_id_write
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef struct packed {
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic            vld;
  } idex_t;

  localparam idex_t BUBBLE = '{ir: NOP_INSTR, pc: '0, a: '0, b: '0, imm: '0, vld: 1'b0};

  idex_t idex_q, idex_d;

  logic [6:0] dec_op;
  logic [4:0] dec_rs1, dec_rs2, ex_rd;
  logic       load_in_ex, rs1_used, rs2_used, hazard, stall;

  assign dec_op  = IF_ID_IR[6:0];
  assign dec_rs1 = IF_ID_IR[19:15];
  assign dec_rs2 = IF_ID_IR[24:20];
  assign ex_rd   = idex_q.ir[11:7];

  // A load with rd=x0 writes nothing, so it can never feed a dependent.
  assign load_in_ex = idex_q.vld && (idex_q.ir[6:0] == OP_LOAD) && (ex_rd != 5'd0);
  assign rs1_used   = !(dec_op == OP_LUI || dec_op == OP_AUIPC || dec_op == OP_JAL);
  assign rs2_used   = (dec_op == OP_R) || (dec_op == OP_S) || (dec_op == OP_B);
  assign hazard     = load_in_ex && ((rs1_used && ex_rd == dec_rs1) ||
                                     (rs2_used && ex_rd == dec_rs2));
  assign stall      = hazard && !flush;

  assign pc_write    = !stall;
  assign if_id_write = !stall;

  always_comb begin
    idex_d = '{ir: IF_ID_IR, pc: IF_ID_PC, a: rs1_data, b: rs2_data, imm: imm, vld: 1'b1};
    if (flush || hazard) idex_d = BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= BUBBLE;
    else     idex_q <= idex_d;
  end

  assign ID_EX_IR    = idex_q.ir;
  assign ID_EX_PC    = idex_q.pc;
  assign ID_EX_A     = idex_q.a;
  assign ID_EX_B     = idex_q.b;
  assign ID_EX_Imm   = idex_q.imm;
  assign ID_EX_valid = idex_q.vld;

`ifdef STALL_COUNT_EN
  // Wraps naturally at 2^CNT_W-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst)        stall_count <= '0;
    else if (stall) stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed load-use / flush / reset scenarios for
// id_ex_stage. Inputs are driven 1ns after a rising edge and outputs are
// sampled there too. Define STALL_COUNT_EN to also cover stall_count.
module tb_id_ex_stage;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD_X5  = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] ADD_X0  = 32'h00200333; // add x6,x0,x2
  localparam logic [31:0] LUI_X5  = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] SW_X5   = 32'h00512223; // sw  x5,4(x2)

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] if_id_ir, if_id_pc, rs1_data, rs2_data, imm;
  logic [31:0] id_ex_ir, id_ex_pc, id_ex_a, id_ex_b, id_ex_imm;
  logic        id_ex_valid, pc_write, if_id_write;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .IF_ID_IR(if_id_ir), .IF_ID_PC(if_id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
    .ID_EX_IR(id_ex_ir), .ID_EX_PC(id_ex_pc), .ID_EX_A(id_ex_a),
    .ID_EX_B(id_ex_b), .ID_EX_Imm(id_ex_imm), .ID_EX_valid(id_ex_valid),
    .pc_write(pc_write),
`ifdef STALL_COUNT_EN
    .if_id_write(if_id_write),
    .stall_count(stall_count)
`else
    .if_id_write(if_id_write)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a decode-stage instruction and let combinational outputs settle.
  task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    if_id_ir = ir; if_id_pc = pc; rs1_data = a; rs2_data = b; imm = im;
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".ir"},  id_ex_ir, NOP);
    chk({tag, ".vld"}, id_ex_valid, 1'b0);
    chk({tag, ".pc"},  id_ex_pc, 32'd0);
    chk({tag, ".a"},   id_ex_a, 32'd0);
    chk({tag, ".b"},   id_ex_b, 32'd0);
    chk({tag, ".imm"}, id_ex_imm, 32'd0);
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef STALL_COUNT_EN
    chk(tag, stall_count, exp);
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(LW_X5, 32'h80, 32'h11, 32'h22, 32'h0);
    tick(); tick();
    // 1. reset
    chk_bubble("rst");
    chk("rst.pc_write", pc_write, 1'b1);
    chk("rst.if_id_write", if_id_write, 1'b1);
    chk_cnt("rst.cnt", 0);

    // 2. lw x5 -> add x6,x5,x2 : one stall, one bubble
    rst = 1'b0;
    drive(LW_X5, 32'h100, 32'h1000, 32'h0, 32'h0);
    tick();
    chk("t2.lw_ir", id_ex_ir, LW_X5);
    chk("t2.lw_vld", id_ex_valid, 1'b1);
    chk("t2.lw_pc", id_ex_pc, 32'h100);
    chk("t2.lw_a", id_ex_a, 32'h1000);
    drive(ADD_X5, 32'h104, 32'h55, 32'h66, 32'h7);
    chk("t2.pc_write_stall", pc_write, 1'b0);
    chk("t2.if_id_write_stall", if_id_write, 1'b0);
    tick();
    chk_bubble("t2.bub");
    chk("t2.pc_write_after", pc_write, 1'b1);
    chk("t2.if_id_write_after", if_id_write, 1'b1);
    tick();
    chk("t2.add_ir", id_ex_ir, ADD_X5);
    chk("t2.add_vld", id_ex_valid, 1'b1);
    chk("t2.add_pc", id_ex_pc, 32'h104);
    chk("t2.add_a", id_ex_a, 32'h55);
    chk("t2.add_b", id_ex_b, 32'h66);
    chk("t2.add_imm", id_ex_imm, 32'h7);
    chk_cnt("t2.cnt", 1);

    // 3. lw x0 never creates a hazard
    drive(LW_X0, 32'h200, 32'h0, 32'h0, 32'h0);
    tick();
    drive(ADD_X0, 32'h204, 32'h0, 32'h9, 32'h0);
    chk("t3.pc_write", pc_write, 1'b1);
    tick();
    chk("t3.add_ir", id_ex_ir, ADD_X0);
    chk("t3.add_vld", id_ex_valid, 1'b1);

    // 4a. lui does not read rs1 -> no stall
    drive(LW_X5, 32'h300, 32'h0, 32'h0, 32'h0);
    tick();
    drive(LUI_X5, 32'h304, 32'h0, 32'h0, 32'h12345000);
    chk("t4a.pc_write", pc_write, 1'b1);
    tick();
    chk("t4a.lui_ir", id_ex_ir, LUI_X5);
    chk("t4a.lui_imm", id_ex_imm, 32'h12345000);

    // 4b. sw reads x5 through rs2 -> stall
    drive(LW_X5, 32'h400, 32'h0, 32'h0, 32'h0);
    tick();
    drive(SW_X5, 32'h404, 32'h0, 32'hABCD, 32'h4);
    chk("t4b.pc_write", pc_write, 1'b0);
    tick();
    chk_bubble("t4b.bub");
    tick();
    chk("t4b.sw_ir", id_ex_ir, SW_X5);
    chk("t4b.sw_b", id_ex_b, 32'hABCD);
    chk_cnt("t4b.cnt", 2);

    // 5. flush in hazard cycle: bubble, no stall, counter unchanged
    drive(LW_X5, 32'h500, 32'h0, 32'h0, 32'h0);
    tick();
    flush = 1'b1;
    drive(ADD_X5, 32'h504, 32'h1, 32'h2, 32'h0);
    chk("t5.pc_write", pc_write, 1'b1);
    chk("t5.if_id_write", if_id_write, 1'b1);
    tick();
    flush = 1'b0;
    chk_bubble("t5.bub");
    chk_cnt("t5.cnt", 2);

    // 6. reset during the stall cycle
    drive(LW_X5, 32'h600, 32'h0, 32'h0, 32'h0);
    tick();
    drive(ADD_X5, 32'h604, 32'h3, 32'h4, 32'h0);
    chk("t6.pc_write_stall", pc_write, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_bubble("t6.rst");
    chk_cnt("t6.cnt", 0);
    chk("t6.pc_write_after", pc_write, 1'b1);
    tick();
    chk("t6.add_ir", id_ex_ir, ADD_X5);
    chk("t6.add_vld", id_ex_valid, 1'b1);
    chk("t6.add_a", id_ex_a, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
